// File: rtl/dual_issue_hazard_unit_if.sv
// Decode-slot bundle and issue/forwarding results exchanged with the dual-issue hazard unit.
interface dual_issue_hazard_unit_if #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned FWD_W      = 3
);
    logic                  s0_valid, s1_valid;
    logic [REG_ADDR_W-1:0] s0_rs, s0_rt, s1_rs, s1_rt;
    logic                  s0_rreg1, s0_rreg2, s1_rreg1, s1_rreg2;
    logic [REG_ADDR_W-1:0] s0_wa, s1_wa;
    logic                  s0_wreg, s0_mreg, s0_mem, s0_branch, s0_md, s0_hilo;
    logic                  s1_wreg, s1_mreg, s1_mem, s1_branch, s1_md, s1_hilo;
    logic                  pipe_adv, flush;
    logic                  issue0, issue1;
    logic [FWD_W-1:0]      s0_fwrd1, s0_fwrd2, s1_fwrd1, s1_fwrd2;
    logic                  stallreq_id, md_busy;

    modport master (
        output s0_valid, s0_rs, s0_rt, s0_rreg1, s0_rreg2, s0_wa, s0_wreg, s0_mreg,
               s0_mem, s0_branch, s0_md, s0_hilo,
               s1_valid, s1_rs, s1_rt, s1_rreg1, s1_rreg2, s1_wa, s1_wreg, s1_mreg,
               s1_mem, s1_branch, s1_md, s1_hilo, pipe_adv, flush,
        input  issue0, issue1, s0_fwrd1, s0_fwrd2, s1_fwrd1, s1_fwrd2, stallreq_id, md_busy
    );

    modport slave (
        input  s0_valid, s0_rs, s0_rt, s0_rreg1, s0_rreg2, s0_wa, s0_wreg, s0_mreg,
               s0_mem, s0_branch, s0_md, s0_hilo,
               s1_valid, s1_rs, s1_rt, s1_rreg1, s1_rreg2, s1_wa, s1_wreg, s1_mreg,
               s1_mem, s1_branch, s1_md, s1_hilo, pipe_adv, flush,
        output issue0, issue1, s0_fwrd1, s0_fwrd2, s1_fwrd1, s1_fwrd2, stallreq_id, md_busy
    );
endinterface

// File: rtl/dual_issue_hazard_unit.sv
// Dual-issue ID hazard unit: in-flight write scoreboard, forwarding selects, pairing and stalls.
// Optional performance counters are enabled with `define HAZARD_PERF_CNT_EN.
module dual_issue_hazard_unit #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned STAGES     = 3,
    parameter int unsigned LOAD_READY = 2,
    parameter int unsigned MD_LAT     = 32,
    parameter int unsigned FWD_W      = 3
) (
    input  logic cpu_clk_50M,
    input  logic cpu_rst,
    dual_issue_hazard_unit_if.slave bus
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_single_cnt,
    output logic [31:0] perf_dual_cnt
`endif
);

    logic [STAGES-1:0][1:0]                 sb_v, sb_ld;
    logic [STAGES-1:0][1:0][REG_ADDR_W-1:0] sb_wa;
    logic [5:0]                             md_cnt;

    logic [3:0][REG_ADDR_W-1:0] src;
    logic [3:0]                 src_rd, luh;
    logic [3:0][FWD_W-1:0]      sel;
    logic md_busy_int, md_haz0, md_haz1, raw01, s1_block, pair_ok, ok0, live;
    logic issue0_int, issue1_int, stall_int;

    // Scan oldest stage first so the youngest match (stage 0, lane 1) overwrites last.
    always_comb begin
        src    = {bus.s1_rt, bus.s1_rs, bus.s0_rt, bus.s0_rs};
        src_rd = {bus.s1_rreg2, bus.s1_rreg1, bus.s0_rreg2, bus.s0_rreg1};
        sel    = '0;
        luh    = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            for (int unsigned kk = STAGES; kk > 0; kk--) begin
                for (int unsigned l = 0; l < 2; l++) begin
                    if (src_rd[i] && (src[i] != '0) && sb_v[kk-1][l] && (sb_wa[kk-1][l] == src[i])) begin
                        sel[i] = FWD_W'(2 * (kk - 1) + l + 1);
                        luh[i] = sb_ld[kk-1][l] && ((kk - 1) < LOAD_READY);
                    end
                end
            end
        end
    end

    always_comb begin
        md_busy_int = (md_cnt != '0);
        md_haz0     = (bus.s0_md | bus.s0_hilo) & md_busy_int;
        md_haz1     = (bus.s1_md | bus.s1_hilo) & md_busy_int;
        raw01       = bus.s0_wreg & (bus.s0_wa != '0) &
                      ((bus.s1_rreg1 & (bus.s1_rs == bus.s0_wa)) |
                       (bus.s1_rreg2 & (bus.s1_rt == bus.s0_wa)));
        s1_block    = luh[2] | luh[3] | md_haz1 | raw01 | (bus.s0_mem & bus.s1_mem) |
                      ((bus.s0_md | bus.s0_hilo) & (bus.s1_md | bus.s1_hilo)) | bus.s1_branch;
        pair_ok     = bus.s1_valid & ~s1_block;
        ok0         = bus.s0_valid & ~luh[0] & ~luh[1] & ~md_haz0 & ~(bus.s0_branch & ~pair_ok);
        live        = ~cpu_rst & ~bus.flush;
        issue0_int  = live & ok0 & bus.pipe_adv;
        issue1_int  = issue0_int & pair_ok;
        stall_int   = live & bus.s0_valid & ~ok0;
    end

    assign bus.issue0      = issue0_int;
    assign bus.issue1      = issue1_int;
    assign bus.stallreq_id = stall_int;
    assign bus.md_busy     = ~cpu_rst & md_busy_int;
    assign bus.s0_fwrd1    = cpu_rst ? '0 : sel[0];
    assign bus.s0_fwrd2    = cpu_rst ? '0 : sel[1];
    assign bus.s1_fwrd1    = cpu_rst ? '0 : sel[2];
    assign bus.s1_fwrd2    = cpu_rst ? '0 : sel[3];

    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst || bus.flush) begin
            sb_v <= '0;
        end else if (bus.pipe_adv) begin
            for (int unsigned k = 1; k < STAGES; k++) begin
                sb_v[k]  <= sb_v[k-1];
                sb_wa[k] <= sb_wa[k-1];
                sb_ld[k] <= sb_ld[k-1];
            end
            sb_v[0][0]  <= issue0_int & bus.s0_wreg & (bus.s0_wa != '0);
            sb_v[0][1]  <= issue1_int & bus.s1_wreg & (bus.s1_wa != '0);
            sb_wa[0][0] <= bus.s0_wa;
            sb_wa[0][1] <= bus.s1_wa;
            sb_ld[0][0] <= bus.s0_mreg;
            sb_ld[0][1] <= bus.s1_mreg;
        end
    end

    // Occupancy runs on wall-clock cycles, independent of pipe_adv.
    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst || bus.flush) begin
            md_cnt <= '0;
        end else if ((issue0_int & bus.s0_md) | (issue1_int & bus.s1_md)) begin
            md_cnt <= 6'(MD_LAT - 1);
        end else if (md_busy_int) begin
            md_cnt <= md_cnt - 6'd1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            perf_stall_cnt  <= '0;
            perf_single_cnt <= '0;
            perf_dual_cnt   <= '0;
        end else begin
            if (stall_int && (perf_stall_cnt != '1))
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (issue0_int && !issue1_int && (perf_single_cnt != '1))
                perf_single_cnt <= perf_single_cnt + 32'd1;
            if (issue1_int && (perf_dual_cnt != '1))
                perf_dual_cnt <= perf_dual_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dual_issue_hazard_unit.sv
// Self-checking bench for dual_issue_hazard_unit: directed scenarios plus random traffic vs a bundle-history model.
module tb_dual_issue_hazard_unit;
    localparam int unsigned STAGES     = 3;
    localparam int unsigned LOAD_READY = 2;
    localparam int unsigned MD_LAT     = 32;
    localparam logic [5:0] F_W = 6'b100000, F_LD = 6'b010000, F_MEM = 6'b001000;
    localparam logic [5:0] F_BR = 6'b000100, F_MD = 6'b000010, F_HL = 6'b000001;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    dual_issue_hazard_unit_if #(.REG_ADDR_W(5), .FWD_W(3)) bus ();

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] p_stall, p_single, p_dual;
`endif

    dual_issue_hazard_unit #(
        .REG_ADDR_W(5), .STAGES(STAGES), .LOAD_READY(LOAD_READY), .MD_LAT(MD_LAT), .FWD_W(3)
    ) dut (
        .cpu_clk_50M(clk),
        .cpu_rst(rst),
        .bus(bus)
`ifdef HAZARD_PERF_CNT_EN
        , .perf_stall_cnt(p_stall), .perf_single_cnt(p_single), .perf_dual_cnt(p_dual)
`endif
    );

    // Reference: newest-first history of issued bundles, md readiness as an absolute cycle number.
    typedef struct packed {
        logic [1:0]      v;
        logic [1:0]      ld;
        logic [1:0][4:0] wa;
    } bundle_t;

    bundle_t    hist[$];
    int         cyc = 0;
    int         md_free = 0;
    logic       e_issue0, e_issue1, e_stall, e_md_busy;
    logic [2:0] e_f[4];

    function automatic void lookup(input logic rd, input logic [4:0] a,
                                   output logic [2:0] sel, output logic lu);
        sel = 3'd0;
        lu  = 1'b0;
        if (rd && a != 5'd0)
            for (int k = 0; k < hist.size(); k++)
                for (int l = 1; l >= 0; l--)
                    if (sel == 3'd0 && hist[k].v[l] && hist[k].wa[l] == a) begin
                        sel = 3'(1 + 2 * k + l);
                        lu  = hist[k].ld[l] && (k < LOAD_READY);
                    end
    endfunction

    function automatic void model_eval();
        logic [3:0] lu;
        logic busy, s0_any, s1_any, raw, s1_ok, s0_ok;
        lookup(bus.s0_rreg1, bus.s0_rs, e_f[0], lu[0]);
        lookup(bus.s0_rreg2, bus.s0_rt, e_f[1], lu[1]);
        lookup(bus.s1_rreg1, bus.s1_rs, e_f[2], lu[2]);
        lookup(bus.s1_rreg2, bus.s1_rt, e_f[3], lu[3]);
        busy   = (cyc < md_free);
        s0_any = bus.s0_md || bus.s0_hilo;
        s1_any = bus.s1_md || bus.s1_hilo;
        raw    = bus.s0_wreg && bus.s0_wa != 5'd0 &&
                 ((bus.s1_rreg1 && bus.s1_rs == bus.s0_wa) || (bus.s1_rreg2 && bus.s1_rt == bus.s0_wa));
        s1_ok  = bus.s1_valid && lu[3:2] == 2'b00 && !(s1_any && busy) && !raw &&
                 !(bus.s0_mem && bus.s1_mem) && !(s0_any && s1_any) && !bus.s1_branch;
        s0_ok  = bus.s0_valid && lu[1:0] == 2'b00 && !(s0_any && busy) && !(bus.s0_branch && !s1_ok);
        e_issue0  = !rst && !bus.flush && bus.pipe_adv && s0_ok;
        e_issue1  = e_issue0 && s1_ok;
        e_stall   = !rst && !bus.flush && bus.s0_valid && !s0_ok;
        e_md_busy = !rst && busy;
        if (rst)
            for (int i = 0; i < 4; i++) e_f[i] = 3'd0;
    endfunction

    function automatic void model_commit();
        bundle_t b;
        if (rst || bus.flush) begin
            hist.delete();
            md_free = 0;
        end else begin
            if (bus.pipe_adv) begin
                b.v[0]  = e_issue0 && bus.s0_wreg && bus.s0_wa != 5'd0;
                b.v[1]  = e_issue1 && bus.s1_wreg && bus.s1_wa != 5'd0;
                b.wa[0] = bus.s0_wa;
                b.wa[1] = bus.s1_wa;
                b.ld[0] = bus.s0_mreg;
                b.ld[1] = bus.s1_mreg;
                hist.push_front(b);
                if (hist.size() > STAGES) void'(hist.pop_back());
            end
            if ((e_issue0 && bus.s0_md) || (e_issue1 && bus.s1_md))
                md_free = cyc + MD_LAT;
        end
        cyc++;
    endfunction

    task automatic tick();
        model_eval();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        {bus.s0_valid, bus.s0_rs, bus.s0_rt, bus.s0_rreg1, bus.s0_rreg2, bus.s0_wa} = '0;
        {bus.s0_wreg, bus.s0_mreg, bus.s0_mem, bus.s0_branch, bus.s0_md, bus.s0_hilo} = '0;
        {bus.s1_valid, bus.s1_rs, bus.s1_rt, bus.s1_rreg1, bus.s1_rreg2, bus.s1_wa} = '0;
        {bus.s1_wreg, bus.s1_mreg, bus.s1_mem, bus.s1_branch, bus.s1_md, bus.s1_hilo} = '0;
        bus.pipe_adv = 1'b1;
        bus.flush    = 1'b0;
    endtask

    task automatic set_s0(input logic [4:0] rs, input logic r1, input logic [4:0] rt,
                          input logic r2, input logic [4:0] wa, input logic [5:0] f);
        bus.s0_valid = 1'b1;
        bus.s0_rs = rs; bus.s0_rreg1 = r1; bus.s0_rt = rt; bus.s0_rreg2 = r2; bus.s0_wa = wa;
        {bus.s0_wreg, bus.s0_mreg, bus.s0_mem, bus.s0_branch, bus.s0_md, bus.s0_hilo} = f;
    endtask

    task automatic set_s1(input logic [4:0] rs, input logic r1, input logic [4:0] rt,
                          input logic r2, input logic [4:0] wa, input logic [5:0] f);
        bus.s1_valid = 1'b1;
        bus.s1_rs = rs; bus.s1_rreg1 = r1; bus.s1_rt = rt; bus.s1_rreg2 = r2; bus.s1_wa = wa;
        {bus.s1_wreg, bus.s1_mreg, bus.s1_mem, bus.s1_branch, bus.s1_md, bus.s1_hilo} = f;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] got;
        rst = 1'b1;
        set_s0(3, 1, 4, 1, 5, F_W | F_MD);
        set_s1(5, 1, 0, 0, 6, F_W);
        tick();
        #4;
        got = {bus.issue0, bus.issue1, bus.stallreq_id, bus.md_busy,
               bus.s0_fwrd1, bus.s0_fwrd2, bus.s1_fwrd1, bus.s1_fwrd2};
        vectors++;
        if (got !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_forced got=%h exp=0000", got);
        end
        tick();
        rst = 1'b0;
        idle();
        #4;
        got = {bus.issue0, bus.issue1, bus.stallreq_id, bus.md_busy,
               bus.s0_fwrd1, bus.s0_fwrd2, bus.s1_fwrd1, bus.s1_fwrd2};
        vectors++;
        if (got !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_state got=%h exp=0000", got);
        end
        tick();
    endtask

    task automatic test_dual_forward();
        do_reset();
        set_s0(1, 1, 2, 1, 3, F_W);
        set_s1(1, 1, 2, 1, 4, F_W);
        #4;
        vectors++;
        if ({bus.issue0, bus.issue1, bus.stallreq_id} !== 3'b110) begin
            miscompares++;
            $display("FAIL dual_issue got=%b exp=110", {bus.issue0, bus.issue1, bus.stallreq_id});
        end
        tick();
        set_s0(3, 1, 0, 1, 10, F_W);
        set_s1(4, 1, 0, 0, 11, F_W);
        #4;
        vectors++;
        if ({bus.s0_fwrd1, bus.s1_fwrd1, bus.s0_fwrd2, bus.issue0, bus.issue1} !== {3'd1, 3'd2, 3'd0, 2'b11}) begin
            miscompares++;
            $display("FAIL fwd_stage0 got=%0d/%0d/%0d iss=%b%b exp=1/2/0 iss=11",
                     bus.s0_fwrd1, bus.s1_fwrd1, bus.s0_fwrd2, bus.issue0, bus.issue1);
        end
        tick();
        set_s0(1, 1, 2, 1, 9, F_W);
        set_s1(1, 1, 2, 1, 9, F_W);
        tick();
        idle();
        set_s0(9, 1, 0, 0, 0, 6'b0);
        #4;
        vectors++;
        if (bus.s0_fwrd1 !== 3'd2) begin
            miscompares++;
            $display("FAIL lane_priority got=%0d exp=2", bus.s0_fwrd1);
        end
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        set_s0(1, 1, 0, 0, 5, F_W | F_LD | F_MEM);
        #4;
        vectors++;
        if (bus.issue0 !== 1'b1) begin
            miscompares++;
            $display("FAIL load_issue got=%b exp=1", bus.issue0);
        end
        tick();
        idle();
        set_s0(5, 1, 0, 0, 12, F_W);
        for (int i = 0; i < 2; i++) begin
            #4;
            vectors++;
            if ({bus.stallreq_id, bus.issue0} !== 2'b10) begin
                miscompares++;
                $display("FAIL load_use_stall cycle=%0d got=%b exp=10", i, {bus.stallreq_id, bus.issue0});
            end
            tick();
        end
        #4;
        vectors++;
        if ({bus.stallreq_id, bus.issue0, bus.s0_fwrd1} !== {2'b01, 3'd5}) begin
            miscompares++;
            $display("FAIL load_use_release got=%b/%b/%0d exp=0/1/5", bus.stallreq_id, bus.issue0, bus.s0_fwrd1);
        end
        tick();
    endtask

    task automatic test_pairing();
        do_reset();
        set_s0(1, 1, 2, 1, 7, F_W);
        set_s1(7, 1, 0, 0, 13, F_W);
        #4;
        vectors++;
        if ({bus.issue0, bus.issue1, bus.stallreq_id} !== 3'b100) begin
            miscompares++;
            $display("FAIL intra_raw got=%b exp=100", {bus.issue0, bus.issue1, bus.stallreq_id});
        end
        tick();
        set_s0(1, 1, 0, 0, 8, F_W | F_LD | F_MEM);
        set_s1(1, 1, 2, 1, 0, F_MEM);
        #4;
        vectors++;
        if ({bus.issue0, bus.issue1, bus.stallreq_id} !== 3'b100) begin
            miscompares++;
            $display("FAIL mem_pair got=%b exp=100", {bus.issue0, bus.issue1, bus.stallreq_id});
        end
        tick();
    endtask

    task automatic test_md();
        do_reset();
        set_s0(1, 1, 2, 1, 0, F_MD);
        #4;
        vectors++;
        if (bus.issue0 !== 1'b1) begin
            miscompares++;
            $display("FAIL md_issue got=%b exp=1", bus.issue0);
        end
        tick();
        idle();
        set_s0(0, 0, 0, 0, 10, F_W | F_HL);
        for (int i = 0; i < 31; i++) begin
            #4;
            vectors++;
            if ({bus.stallreq_id, bus.issue0, bus.md_busy} !== 3'b101) begin
                miscompares++;
                $display("FAIL md_stall cycle=%0d got=%b exp=101", i, {bus.stallreq_id, bus.issue0, bus.md_busy});
            end
            tick();
        end
        #4;
        vectors++;
        if ({bus.stallreq_id, bus.issue0, bus.md_busy} !== 3'b010) begin
            miscompares++;
            $display("FAIL md_release got=%b exp=010", {bus.stallreq_id, bus.issue0, bus.md_busy});
        end
        tick();
    endtask

    task automatic test_branch_pair();
        do_reset();
        set_s0(1, 1, 0, 0, 6, F_W | F_LD | F_MEM);
        tick();
        idle();
        set_s0(1, 1, 2, 1, 0, F_BR);
        set_s1(6, 1, 0, 0, 14, F_W);
        for (int i = 0; i < 2; i++) begin
            #4;
            vectors++;
            if ({bus.issue0, bus.issue1, bus.stallreq_id} !== 3'b001) begin
                miscompares++;
                $display("FAIL branch_hold cycle=%0d got=%b exp=001", i, {bus.issue0, bus.issue1, bus.stallreq_id});
            end
            tick();
        end
        #4;
        vectors++;
        if ({bus.issue0, bus.issue1, bus.stallreq_id, bus.s1_fwrd1} !== {3'b110, 3'd5}) begin
            miscompares++;
            $display("FAIL branch_pair got=%b/%0d exp=110/5", {bus.issue0, bus.issue1, bus.stallreq_id}, bus.s1_fwrd1);
        end
        tick();
        idle();
        set_s0(1, 1, 2, 1, 0, F_BR);
        #4;
        vectors++;
        if ({bus.issue0, bus.stallreq_id} !== 2'b01) begin
            miscompares++;
            $display("FAIL branch_no_slot got=%b exp=01", {bus.issue0, bus.stallreq_id});
        end
        tick();
    endtask

    task automatic test_flush();
        do_reset();
        set_s0(1, 1, 0, 0, 5, F_W | F_LD | F_MEM);
        set_s1(1, 1, 2, 1, 0, F_MD);
        #4;
        vectors++;
        if ({bus.issue0, bus.issue1} !== 2'b11) begin
            miscompares++;
            $display("FAIL flush_setup got=%b exp=11", {bus.issue0, bus.issue1});
        end
        tick();
        idle();
        bus.flush = 1'b1;
        set_s0(5, 1, 0, 0, 12, F_W);
        #4;
        vectors++;
        if ({bus.issue0, bus.issue1, bus.stallreq_id, bus.md_busy} !== 4'b0001) begin
            miscompares++;
            $display("FAIL flush_cycle got=%b exp=0001", {bus.issue0, bus.issue1, bus.stallreq_id, bus.md_busy});
        end
        tick();
        bus.flush = 1'b0;
        #4;
        vectors++;
        if ({bus.s0_fwrd1, bus.md_busy, bus.stallreq_id, bus.issue0} !== {3'd0, 3'b001}) begin
            miscompares++;
            $display("FAIL after_flush got=%0d/%b exp=0/001", bus.s0_fwrd1, {bus.md_busy, bus.stallreq_id, bus.issue0});
        end
        tick();
        idle();
        set_s0(1, 1, 0, 0, 5, F_W | F_LD | F_MEM);
        tick();
        idle();
        set_s0(5, 1, 0, 0, 12, F_W);
        #4;
        vectors++;
        if (bus.stallreq_id !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_rst_stall got=%b exp=1", bus.stallreq_id);
        end
        tick();
        rst = 1'b1;
        tick();
        #4;
        vectors++;
        if ({bus.issue0, bus.issue1, bus.stallreq_id, bus.md_busy, bus.s0_fwrd1} !== 7'b0) begin
            miscompares++;
            $display("FAIL rst_mid_stall got=%b exp=0000000",
                     {bus.issue0, bus.issue1, bus.stallreq_id, bus.md_busy, bus.s0_fwrd1});
        end
        tick();
        rst = 1'b0;
        #4;
        vectors++;
        if ({bus.stallreq_id, bus.issue0, bus.s0_fwrd1} !== {2'b01, 3'd0}) begin
            miscompares++;
            $display("FAIL post_rst got=%b/%b/%0d exp=0/1/0", bus.stallreq_id, bus.issue0, bus.s0_fwrd1);
        end
        tick();
    endtask

    task automatic rand_inputs();
        logic m0, m1;
        m0 = ($urandom_range(0, 2) == 0);
        m1 = ($urandom_range(0, 2) == 0);
        bus.s0_valid = ($urandom_range(0, 9) != 0);
        bus.s0_rs = 5'($urandom_range(0, 7)); bus.s0_rt = 5'($urandom_range(0, 7));
        bus.s0_rreg1 = 1'($urandom); bus.s0_rreg2 = 1'($urandom);
        bus.s0_wa = 5'($urandom_range(0, 7)); bus.s0_wreg = ($urandom_range(0, 3) != 0);
        bus.s0_mem = m0; bus.s0_mreg = m0 & 1'($urandom);
        bus.s0_branch = ($urandom_range(0, 9) == 0);
        bus.s0_md = ($urandom_range(0, 24) == 0); bus.s0_hilo = ($urandom_range(0, 9) == 0);
        bus.s1_valid = ($urandom_range(0, 4) != 0);
        bus.s1_rs = 5'($urandom_range(0, 7)); bus.s1_rt = 5'($urandom_range(0, 7));
        bus.s1_rreg1 = 1'($urandom); bus.s1_rreg2 = 1'($urandom);
        bus.s1_wa = 5'($urandom_range(0, 7)); bus.s1_wreg = ($urandom_range(0, 3) != 0);
        bus.s1_mem = m1; bus.s1_mreg = m1 & 1'($urandom);
        bus.s1_branch = ($urandom_range(0, 14) == 0);
        bus.s1_md = ($urandom_range(0, 24) == 0); bus.s1_hilo = ($urandom_range(0, 9) == 0);
        bus.pipe_adv = ($urandom_range(0, 4) != 0);
        bus.flush = ($urandom_range(0, 39) == 0);
        rst = ($urandom_range(0, 149) == 0);
    endtask

    task automatic test_random();
        logic [15:0] got, exp;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            rand_inputs();
            #4;
            model_eval();
            got = {bus.issue0, bus.issue1, bus.stallreq_id, bus.md_busy,
                   bus.s0_fwrd1, bus.s0_fwrd2, bus.s1_fwrd1, bus.s1_fwrd2};
            exp = {e_issue0, e_issue1, e_stall, e_md_busy, e_f[0], e_f[1], e_f[2], e_f[3]};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL random n=%0d got=%h exp=%h (iss0 iss1 stall busy f01 f02 f11 f12)", n, got, exp);
            end
            tick();
        end
        rst = 1'b0;
        idle();
    endtask

    initial begin
        #1000000;
        miscompares++;
        $display("FAIL watchdog time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        rst = 1'b1;
        idle();
        @(posedge clk);
        #1;
        test_reset();
        test_dual_forward();
        test_load_use();
        test_pairing();
        test_md();
        test_branch_pair();
        test_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/dual_issue_hazard_unit.md
Name: dual_issue_hazard_unit

Overview:
- Parametrised issue and hazard controller for the dual-issue ID stage.
- Successor to the single-slot decode-time forwarding/stall logic. Tracks in-flight register writes of both lanes in an internal scoreboard spanning STAGES pipeline stages.
- Generates per-source forwarding selects for slot 0 and slot 1, decides whether slot 1 pairs with slot 0, and stalls on load-use and on multi-cycle mult/div HI/LO occupancy.

Parameters:
- REG_ADDR_W, 5: register address width.
- STAGES, 3: number of post-ID stages tracked (stage 0 = EXE); valid range 1..6.
- LOAD_READY, 2: first stage index at which load data can be forwarded; 1..STAGES-1.
- MD_LAT, 32: mult/div occupancy in cycles; 1..63.
- FWD_W, 3: forwarding select width; must satisfy 2^FWD_W >= 2*STAGES+1.

Ports:
- cpu_clk_50M  in  1  clock.
- cpu_rst  in  1  synchronous reset, active-high.
- sN_valid  in  1  slot N (N=0,1) holds a decoded instruction.
- sN_rs, sN_rt  in  REG_ADDR_W  source register addresses.
- sN_rreg1, sN_rreg2  in  1  source rs / rt is read.
- sN_wa  in  REG_ADDR_W  destination register.
- sN_wreg  in  1  destination is written.
- sN_mreg  in  1  instruction is a load.
- sN_mem  in  1  load or store.
- sN_branch  in  1  branch or jump.
- sN_md  in  1  mult/div start.
- sN_hilo  in  1  mfhi/mflo/mthi/mtlo.
- pipe_adv  in  1  downstream pipeline advances this cycle.
- flush  in  1  exception/eret flush.
- issue0, issue1  out  1  slot accepted this cycle.
- sN_fwrd1, sN_fwrd2  out  FWD_W  forwarding select for rs / rt.
- stallreq_id  out  1  ID stage must hold.
- md_busy  out  1  mult/div occupancy counter nonzero.

Behaviour:
Scoreboard
- STAGES x 2 lanes. Each entry holds {v, wa, ld}.
- Registered; updates only on the rising edge of cpu_clk_50M.
- When pipe_adv=1: stage k+1 <= stage k. Stage 0 lane L <= {issueL & sL_wreg & sL_wa!=0, sL_wa, sL_mreg}.
- When pipe_adv=0: scoreboard holds.

Forwarding (combinational)
- For each read source, search stage 0 first, then stage 1, and so on. Within a stage, lane 1 beats lane 0 (lane 1 is younger).
- On the first match with v=1 and wa==src: select = 1+2*k+L.
- No match, or source not read: select = 0 (register file).
- Address 0 never matches.

Load-use
- A source matching an entry with ld=1 in a stage k < LOAD_READY is a hazard. This applies only when that entry is the first match.

Slot 0 issue
- issue0 = s0_valid & pipe_adv & no slot-0 hazard & no md hazard for slot 0 & branch-pair rule satisfied.

Slot 1 issue
- issue1 additionally requires all of the following:
  - issue0=1.
  - s1 does not read s0_wa while s0_wreg=1 and s0_wa!=0 (intra-bundle RAW).
  - Not (s0_mem & s1_mem).
  - Not (s0_md|s0_hilo) together with (s1_md|s1_hilo).
  - s1 is not a branch.
- If s0_wreg & s1_wreg and the addresses are equal, slot 1 wins forwarding (lane 1 priority).

Branch-pair rule
- If s0_branch=1, slot 1 is its delay slot and the two issue together or not at all.
- If s1_valid=0, or slot 1 has any hazard: issue0=issue1=0 and stallreq_id=1.

md hazard
- Any sN_md or sN_hilo while md_busy=1 blocks that slot.

md counter
- 6-bit counter.
- Issuing an md instruction loads MD_LAT-1 (MD_LAT=1 loads 0).
- Otherwise decrements each cycle while nonzero. Counts independently of pipe_adv.
- md_busy = (cnt != 0).

stallreq_id
- 1 when s0_valid=1 and issue0=0 for a hazard reason.
- Not asserted solely because pipe_adv=0.
- Slot 1 not pairing is not a stall: slot 1 is re-presented as slot 0 next cycle by the fetch buffer.

flush
- Clears all scoreboard v bits and the md counter on the next edge.
- Has priority over pipe_adv.
- issue0=issue1=0 during the flush cycle.

Reset
- Synchronous: all v=0, counter=0.
- During cpu_rst=1, all outputs are forced to 0.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- With the macro defined: adds outputs perf_stall_cnt[31:0], perf_single_cnt[31:0] and perf_dual_cnt[31:0].
  - perf_stall_cnt counts cycles with stallreq_id=1.
  - perf_single_cnt counts cycles with issue0 & ~issue1.
  - perf_dual_cnt counts cycles with issue0 & issue1.
  - All three saturate at 32'hFFFFFFFF, clear on cpu_rst, and are unaffected by flush.
- Without the macro: the ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Cycle 0: s0 = addu $3 and s1 = addu $4 dual-issue. Cycle 1: s0 reads $3, s1 reads $4 -> s0_fwrd1=1 (stage 0 lane 0), s1_fwrd1=2 (stage 0 lane 1), issue0=issue1=1.
2. Load: lw $5 issues. Next cycle s0 reads $5 -> stallreq_id=1 for 2 cycles (LOAD_READY=2), then issue0=1 with fwrd=5 (stage 2 lane 0).
3. s0 writes $7, s1 reads $7 -> issue0=1, issue1=0, stallreq_id=0. Both lw/sw in one bundle -> issue1=0.
4. div issues. An mflo presented 1 cycle later -> stalled 31 cycles (MD_LAT=32), issued on the cycle md_busy falls.
5. s0 = beq, s1 = delay slot with load-use hazard -> issue0=issue1=0, stallreq_id=1 until the hazard clears, then both issue in the same cycle.
6. flush asserted with a load in stage 0 and md_busy=1 -> next cycle all fwrd=0, md_busy=0, no stall. Separately, cpu_rst mid-stall -> all outputs 0 the following cycle.
